// File: rtl/unsigned_calc_seq_v_pkg.sv
// unsigned_calc_pkg: shared types and the fixed six-step schedule for 7A - 3B + 6C.
package unsigned_calc_pkg;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    typedef enum logic [1:0] {SEL_A, SEL_B, SEL_C} sel_t;
    localparam int ACC_W = 9;
    localparam int STEP_W = 3;
    localparam logic [STEP_W-1:0] LAST_STEP = 3'd5;
    // A<<3 - A - B<<1 - B + C<<2 + C<<1
    function automatic logic [1:0] step_shift(input logic [STEP_W-1:0] s);
        return (s == 3'd0) ? 2'd3 : (s == 3'd2 || s == 3'd5) ? 2'd1 : (s == 3'd4) ? 2'd2 : 2'd0;
    endfunction
    function automatic sel_t step_sel(input logic [STEP_W-1:0] s);
        return (s < 3'd2) ? SEL_A : (s < 3'd4) ? SEL_B : SEL_C;
    endfunction
    function automatic logic step_sub(input logic [STEP_W-1:0] s);
        return s >= 3'd1 && s <= 3'd3;
    endfunction
endpackage

// File: rtl/unsigned_calc_seq_v_add_sub9.sv
// add_sub9_v: 9-bit ripple add/subtract; subtract inverts b and injects carry-in.
module full_adder_v (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);
    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule

module add_sub9_v (
    input  logic [8:0] i_a,
    input  logic [8:0] i_b,
    input  logic       i_sub,
    output logic [8:0] o_sum
);
    logic [8:0] w_co;
    logic [8:0] w_ci;
    logic       w_unused_cout;
    assign w_ci = {w_co[7:0], i_sub};
    assign w_unused_cout = w_co[8];
    for (genvar g = 0; g < 9; g++) begin : g_fa
        full_adder_v u_fa (
            .i_a (i_a[g]),
            .i_b (i_b[g] ^ i_sub),
            .i_ci(w_ci[g]),
            .o_s (o_sum[g]),
            .o_co(w_co[g])
        );
    end
endmodule

// File: rtl/unsigned_calc_seq_v.sv
// unsigned_calc_seq_v: multi-cycle 7A - 3B + 6C using one shared 9-bit add/sub unit.
module unsigned_calc_seq_v
    import unsigned_calc_pkg::*;
#(
    parameter int DONE_PULSE = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [3:0] i_au,
    input  logic [3:0] i_bu,
    input  logic [3:0] i_cu,
    output logic [7:0] o_fu,
    output logic       o_ovf,
    output logic       o_busy,
    output logic       o_done
);
    state_t            r_state, w_next;
    logic [STEP_W-1:0] r_step;
    logic [3:0]        r_a, r_b, r_c, w_sel;
    logic [ACC_W-1:0]  r_acc, w_opnd, w_sum;
    logic [7:0]        r_fu;
    logic              r_ovf, r_done, w_accept;

    always_comb begin
        w_accept = i_start && (r_state == S_IDLE || (r_state == S_DONE && r_done));
        w_sel    = step_sel(r_step) == SEL_A ? r_a : step_sel(r_step) == SEL_B ? r_b : r_c;
        w_opnd   = {{(ACC_W-4){1'b0}}, w_sel} << step_shift(r_step);
        w_next   = w_accept ? S_RUN :
                   (r_state == S_RUN)  ? ((r_step == LAST_STEP) ? S_DONE : S_RUN) :
                   (r_state == S_DONE) ? ((DONE_PULSE != 0) ? S_IDLE : S_DONE) : S_IDLE;
    end

    add_sub9_v u_alu (
        .i_a  (r_acc),
        .i_b  (w_opnd),
        .i_sub(step_sub(r_step)),
        .o_sum(w_sum)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // The first DONE cycle captures the result; o_done follows one edge later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_c    <= '0;
            r_acc  <= '0;
            r_step <= '0;
            r_fu   <= '0;
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a    <= i_au;
                r_b    <= i_bu;
                r_c    <= i_cu;
                r_acc  <= '0;
                r_step <= '0;
            end else if (r_state == S_RUN) begin
                r_acc  <= w_sum;
                r_step <= r_step + 1'b1;
            end
            if (r_state == S_DONE && !r_done) begin
                r_fu  <= r_acc[7:0];
                r_ovf <= r_acc[8] ^ r_acc[7];
            end
            r_done <= r_state == S_DONE && !w_accept && (!r_done || DONE_PULSE == 0);
        end
    end

    assign o_fu   = r_fu;
    assign o_ovf  = r_ovf;
    assign o_done = r_done;
    assign o_busy = r_state == S_RUN || (r_state == S_DONE && !r_done);
endmodule

// File: tb/tb_unsigned_calc_seq_v.sv
// tb_unsigned_calc_seq_v: random and exhaustive checks of both o_done modes against 7A - 3B + 6C.
module tb_unsigned_calc_seq_v;
    logic       clk = 1'b0, rst_n = 1'b0, st0 = 1'b0, st1 = 1'b0;
    logic [3:0] a0 = '0, b0 = '0, c0 = '0, a1 = '0, b1 = '0, c1 = '0;
    logic [7:0] fu0, fu1;
    logic       ovf0, ovf1, busy0, busy1, done0, done1;
    logic [8:0] e, e2;
    int         total = 0, bad = 0;

    always #5 clk = ~clk;

    unsigned_calc_seq_v #(.DONE_PULSE(1)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(st0), .i_au(a0), .i_bu(b0), .i_cu(c0),
        .o_fu(fu0), .o_ovf(ovf0), .o_busy(busy0), .o_done(done0)
    );
    unsigned_calc_seq_v #(.DONE_PULSE(0)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(st1), .i_au(a1), .i_bu(b1), .i_cu(c1),
        .o_fu(fu1), .o_ovf(ovf1), .o_busy(busy1), .o_done(done1)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] ref_res(input int a, input int b, input int c);
        int v;
        v = 7 * a - 3 * b + 6 * c;
        return {v > 127 || v < -128, v[7:0]};
    endfunction

    task automatic run0(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        logic [8:0] x;
        x = ref_res(a, b, c);
        @(negedge clk);
        a0 = a; b0 = b; c0 = c; st0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st0 = 1'b0; a0 = 4'($urandom); b0 = 4'($urandom); c0 = 4'($urandom);
        chk("run_busy", {busy0, done0}, 2'b10);
        for (int n = 1; n < 7; n++) begin
            @(negedge clk);
            chk("run_busy", {busy0, done0}, 2'b10);
        end
        @(negedge clk);
        chk("run_done", {busy0, done0}, 2'b01);
        chk("run_res", {ovf0, fu0}, x);
        @(negedge clk);
        chk("run_drop", {busy0, done0}, 2'b00);
        chk("run_hold", {ovf0, fu0}, x);
    endtask

    initial begin
        #1;
        chk("rst0", {ovf0, fu0, busy0, done0}, 0);
        chk("rst1", {ovf1, fu1, busy1, done1}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run0(4'd3, 4'd2, 4'd1);
        run0(4'd15, 4'd0, 4'd15);
        run0(4'd0, 4'd15, 4'd0);
        for (int k = 0; k < 6; k++) run0(4'($urandom), 4'($urandom), 4'($urandom));

        // exhaustive sweep with start held high: one result every 8 cycles
        @(negedge clk);
        st0 = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            a0 = i[11:8]; b0 = i[7:4]; c0 = i[3:0];
            e = ref_res(a0, b0, c0);
            repeat (7) @(negedge clk);
            chk("sw_early", {busy0, done0}, 2'b10);
            @(negedge clk);
            chk("sw_done", {busy0, done0}, 2'b01);
            chk("sw_res", {ovf0, fu0}, e);
            if (i == 4095) st0 = 1'b0;
        end
        @(negedge clk);
        chk("sw_idle", {busy0, done0}, 2'b00);

        // starts during RUN are ignored; operands come from E0 only
        e = ref_res(5, 4, 9);
        @(negedge clk);
        a0 = 4'd5; b0 = 4'd4; c0 = 4'd9; st0 = 1'b1;
        @(posedge clk);
        for (int n = 0; n <= 8; n++) begin
            @(negedge clk);
            st0 = (n == 1 || n == 3);
            a0 = 4'($urandom); b0 = 4'($urandom); c0 = 4'($urandom);
            if (n == 7) chk("ign_res", {done0, ovf0, fu0}, {1'b1, e});
            if (n == 8) chk("ign_idle", {busy0, done0}, 2'b00);
        end

        // asynchronous reset mid-run
        @(negedge clk);
        a0 = 4'd1; b0 = 4'd1; c0 = 4'd1; st0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st0 = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst", {busy0, ovf0, fu0}, {1'b1, e});
        #2 rst_n = 1'b0;
        #1 chk("async_rst", {ovf0, fu0, busy0, done0}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_idle", {busy0, done0}, 2'b00);
        run0(4'($urandom), 4'($urandom), 4'($urandom));

        // held-done mode
        a1 = 4'($urandom); b1 = 4'($urandom); c1 = 4'($urandom);
        e = ref_res(a1, b1, c1);
        @(negedge clk);
        st1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st1 = 1'b0; a1 = 4'($urandom); b1 = 4'($urandom); c1 = 4'($urandom);
        chk("h_busy", {busy1, done1}, 2'b10);
        repeat (6) @(negedge clk);
        chk("h_busy6", {busy1, done1}, 2'b10);
        @(negedge clk);
        chk("h_done", {busy1, done1}, 2'b01);
        chk("h_res", {ovf1, fu1}, e);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            chk("h_hold", {busy1, done1, ovf1, fu1}, {2'b01, e});
        end
        e2 = ref_res(a1, b1, c1);
        st1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st1 = 1'b0; a1 = 4'($urandom); b1 = 4'($urandom); c1 = 4'($urandom);
        chk("h_drop", {busy1, done1, ovf1, fu1}, {2'b10, e});
        repeat (6) @(negedge clk);
        chk("h_run6", {busy1, done1}, 2'b10);
        @(negedge clk);
        chk("h_done2", {busy1, done1}, 2'b01);
        chk("h_res2", {ovf1, fu1}, e2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
